// File: rtl/baud_gen_frac_if.sv
// Control/tick bundle for the fractional baud generator.
// The master drives enable and divisor writes; the slave returns the ticks and the pending flag.
interface baud_gen_frac_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
);
    logic              en;
    logic              div_wr;
    logic [DIV_W-1:0]  div_data;
    logic [FRAC_W-1:0] frac_data;
    logic              os_tick;
    logic              bit_tick;
    logic              upd_pend;

    modport master (
        output en, div_wr, div_data, frac_data,
        input  os_tick, bit_tick, upd_pend
    );

    modport slave (
        input  en, div_wr, div_data, frac_data,
        output os_tick, bit_tick, upd_pend
    );
endinterface

// File: rtl/baud_gen_frac.sv
// Fractional baud-tick generator: integer+fractional divisor, double-buffered divisor updates,
// oversample tick plus a bit tick every OS_RATE oversample ticks.
module baud_gen_frac #(
    parameter int DIV_W     = 16,
    parameter int FRAC_W    = 4,
    parameter int OS_RATE   = 16,
    parameter int RESET_DIV = 326
) (
    input  logic            clk,
    input  logic            rst_n,
    baud_gen_frac_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int              OSC_W   = (OS_RATE > 2) ? $clog2(OS_RATE) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = {DIV_W{1'b1}};
    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(RESET_DIV);
    localparam logic [OSC_W-1:0] OS_LAST = OSC_W'(OS_RATE - 1);

    state_t             r_state;
    logic [DIV_W-1:0]   r_shadow_div;
    logic [FRAC_W-1:0]  r_shadow_frac;
    logic [DIV_W-1:0]   r_act_div;
    logic [FRAC_W-1:0]  r_act_frac;
    logic [FRAC_W-1:0]  r_acc;
    logic [DIV_W-1:0]   r_cnt;
    logic [OSC_W-1:0]   r_os_cnt;
    logic               r_upd_pend;

    state_t             w_state_nxt;
    logic [DIV_W-1:0]   w_act_div_nxt;
    logic [FRAC_W-1:0]  w_act_frac_nxt;
    logic [FRAC_W-1:0]  w_acc_nxt;
    logic [DIV_W-1:0]   w_cnt_nxt;
    logic [OSC_W-1:0]   w_os_cnt_nxt;
    logic               w_upd_pend_nxt;

    logic               w_apply;
    logic [DIV_W-1:0]   w_eff_div;
    logic [FRAC_W-1:0]  w_eff_frac;
    logic [FRAC_W-1:0]  w_acc_base;
    logic [FRAC_W:0]    w_sum;
    logic [DIV_W-1:0]   w_period;
    logic               w_tick;

    // A zero divisor would mean a zero-length period; run it as one cycle instead.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d == {DIV_W{1'b0}}) ? DIV_ONE : d;
    endfunction

    // Divisor selection and next-period arithmetic (shadow wins when it is being applied).
    always_comb begin
        w_apply    = (r_state == ST_IDLE) ? 1'b1 : r_upd_pend;
        w_eff_div  = w_apply ? clamp_div(r_shadow_div) : r_act_div;
        w_eff_frac = w_apply ? r_shadow_frac : r_act_frac;
        w_acc_base = (r_state == ST_IDLE) ? {FRAC_W{1'b0}} : r_acc;
        w_sum      = {1'b0, w_acc_base} + {1'b0, w_eff_frac};
        if (w_eff_div == DIV_MAX) begin
            w_period = DIV_MAX;
        end else begin
            w_period = w_eff_div + {{(DIV_W-1){1'b0}}, w_sum[FRAC_W]};
        end
        w_tick = (r_state == ST_RUN) && bus.en && (r_cnt == {DIV_W{1'b0}});
    end

    // Next-state logic; every load also commits the divisor it used and clears the pending flag.
    always_comb begin
        w_state_nxt    = r_state;
        w_act_div_nxt  = r_act_div;
        w_act_frac_nxt = r_act_frac;
        w_acc_nxt      = r_acc;
        w_cnt_nxt      = r_cnt;
        w_os_cnt_nxt   = r_os_cnt;
        w_upd_pend_nxt = r_upd_pend;
        case (r_state)
            ST_IDLE: begin
                w_acc_nxt    = {FRAC_W{1'b0}};
                w_cnt_nxt    = {DIV_W{1'b0}};
                w_os_cnt_nxt = {OSC_W{1'b0}};
                if (bus.en) begin
                    w_state_nxt    = ST_RUN;
                    w_act_div_nxt  = w_eff_div;
                    w_act_frac_nxt = w_eff_frac;
                    w_upd_pend_nxt = 1'b0;
                    w_acc_nxt      = w_sum[FRAC_W-1:0];
                    w_cnt_nxt      = w_period - DIV_ONE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!bus.en) begin
                    w_state_nxt  = ST_IDLE;
                    w_acc_nxt    = {FRAC_W{1'b0}};
                    w_cnt_nxt    = {DIV_W{1'b0}};
                    w_os_cnt_nxt = {OSC_W{1'b0}};
                end else if (w_tick) begin
                    w_act_div_nxt  = w_eff_div;
                    w_act_frac_nxt = w_eff_frac;
                    w_upd_pend_nxt = 1'b0;
                    w_acc_nxt      = w_sum[FRAC_W-1:0];
                    w_cnt_nxt      = w_period - DIV_ONE;
                    w_os_cnt_nxt   = (r_os_cnt == OS_LAST) ? {OSC_W{1'b0}} : r_os_cnt + OSC_W'(1);
                end else begin
                    w_cnt_nxt = r_cnt - DIV_ONE;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_acc_nxt    = {FRAC_W{1'b0}};
                w_cnt_nxt    = {DIV_W{1'b0}};
                w_os_cnt_nxt = {OSC_W{1'b0}};
            end
        endcase
        // A write in the same cycle as a load keeps the flag set for the following boundary.
        w_upd_pend_nxt = w_upd_pend_nxt | bus.div_wr;
    end

    // State register and shadow divisor capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_shadow_div  <= RST_DIV;
            r_shadow_frac <= {FRAC_W{1'b0}};
            r_act_div     <= RST_DIV;
            r_act_frac    <= {FRAC_W{1'b0}};
            r_acc         <= {FRAC_W{1'b0}};
            r_cnt         <= {DIV_W{1'b0}};
            r_os_cnt      <= {OSC_W{1'b0}};
            r_upd_pend    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_act_div  <= w_act_div_nxt;
            r_act_frac <= w_act_frac_nxt;
            r_acc      <= w_acc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_os_cnt   <= w_os_cnt_nxt;
            r_upd_pend <= w_upd_pend_nxt;
            if (bus.div_wr) begin
                r_shadow_div  <= bus.div_data;
                r_shadow_frac <= bus.frac_data;
            end
        end
    end

    assign bus.os_tick  = w_tick;
    assign bus.bit_tick = w_tick && (r_os_cnt == OS_LAST);
    assign bus.upd_pend = r_upd_pend;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Scoreboard bench for baud_gen_frac: expected tick cycles are queued when stimulus is applied
// and matched against observed os_tick/bit_tick pulses.
module tb_baud_gen_frac;

    typedef struct {
        longint cyc;
        bit     bt;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n;
    longint cyc = 0;
    int     n_tests = 0;
    int     n_fail  = 0;
    exp_t   sb_q[$];
    exp_t   mon_e;

    baud_gen_frac_if #(.DIV_W(16), .FRAC_W(4)) bus_if ();

    baud_gen_frac #(
        .DIV_W(16), .FRAC_W(4), .OS_RATE(16), .RESET_DIV(326)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Tick monitor: every os_tick must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus_if.os_tick === 1'b1) begin
                while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                    mon_e = sb_q.pop_front();
                    check_eq("missed_tick", cyc, mon_e.cyc);
                end
                if (sb_q.size() == 0) begin
                    check_eq("extra_tick", bus_if.os_tick, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_eq("tick_cyc", cyc, mon_e.cyc);
                    check_eq("bit_tick", bus_if.bit_tick, mon_e.bt);
                end
            end else if (bus_if.bit_tick !== 1'b0) begin
                check_eq("bit_alone", bus_if.bit_tick, 0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_to(input longint target);
        while (cyc < target) step(1);
    endtask

    task automatic wr(input int d, input int f);
        bus_if.div_wr    = 1'b1;
        bus_if.div_data  = 16'(d);
        bus_if.frac_data = 4'(f);
        step(1);
        bus_if.div_wr = 1'b0;
    endtask

    // Model: period = max(div,1) + carry of a 4-bit phase accumulator, capped at 2^16-1.
    task automatic push_ticks(input longint start, input int n, input int div, input int frac,
                              input int idx0, output longint last);
        int     acc = 0;
        int     p;
        longint t = start;
        exp_t   e;
        for (int k = 1; k <= n; k++) begin
            p = (div == 0) ? 1 : div;
            acc += frac;
            if (acc >= 16) begin
                acc -= 16;
                p++;
            end
            if (p > 65535) p = 65535;
            t += p;
            e.cyc = t;
            e.bt  = ((idx0 + k) % 16 == 0);
            sb_q.push_back(e);
        end
        last = t;
    endtask

    task automatic drain(input string tag);
        check_eq(tag, sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint c, d, l1, last;
        rst_n            = 1'b0;
        bus_if.en        = 1'b0;
        bus_if.div_wr    = 1'b0;
        bus_if.div_data  = 16'd0;
        bus_if.frac_data = 4'd0;
        step(3);
        check_eq("rst_os_tick", bus_if.os_tick, 0);
        check_eq("rst_upd_pend", bus_if.upd_pend, 0);
        rst_n = 1'b1;
        step(2);
        check_eq("idle_os_tick", bus_if.os_tick, 0);

        // Reset divisor: 326-cycle os_tick, bit_tick on the 16th
        bus_if.en = 1'b1;
        c = cyc;
        push_ticks(c, 17, 326, 0, 0, last);
        run_to(last + 1);
        bus_if.en = 1'b0;
        step(2);
        drain("t1_drain");

        // Fractional 5 + 8/16: periods 5,6,5,6...
        wr(5, 8);
        check_eq("t2_pend", bus_if.upd_pend, 1);
        bus_if.en = 1'b1;
        c = cyc;
        push_ticks(c, 32, 5, 8, 0, last);
        step(1);
        check_eq("t2_applied", bus_if.upd_pend, 0);
        check_eq("t2_16th_at_88", sb_q[15].cyc - c, 88);
        run_to(last + 1);
        bus_if.en = 1'b0;
        step(2);
        drain("t2_drain");

        // Mid-period write: current period kept, new one at the boundary
        wr(10, 0);
        bus_if.en = 1'b1;
        c = cyc;
        push_ticks(c, 3, 10, 0, 0, l1);
        push_ticks(l1, 2, 20, 0, 3, last);
        run_to(c + 25);
        bus_if.div_wr   = 1'b1;
        bus_if.div_data = 16'd20;
        step(1);
        bus_if.div_wr = 1'b0;
        check_eq("t3_pend", bus_if.upd_pend, 1);
        run_to(c + 30);
        check_eq("t3_pend_hold", bus_if.upd_pend, 1);
        step(1);
        check_eq("t3_applied", bus_if.upd_pend, 0);
        run_to(last + 1);
        bus_if.en = 1'b0;
        step(2);
        drain("t3_drain");

        // Write coincident with a reload: one more old period, then new
        wr(10, 0);
        bus_if.en = 1'b1;
        c = cyc;
        push_ticks(c, 3, 10, 0, 0, l1);
        push_ticks(l1, 2, 20, 0, 3, last);
        run_to(c + 20);
        check_eq("t4_tick_now", bus_if.os_tick, 1);
        bus_if.div_wr   = 1'b1;
        bus_if.div_data = 16'd20;
        step(1);
        bus_if.div_wr = 1'b0;
        check_eq("t4_pend", bus_if.upd_pend, 1);
        run_to(c + 30);
        check_eq("t4_pend_hold", bus_if.upd_pend, 1);
        step(1);
        check_eq("t4_applied", bus_if.upd_pend, 0);
        run_to(last + 1);
        bus_if.en = 1'b0;
        step(2);
        drain("t4_drain");

        // Divisor 0 -> every cycle; en drop gates the tick; re-enable restarts phase
        wr(0, 0);
        bus_if.en = 1'b1;
        c = cyc;
        push_ticks(c, 20, 0, 0, 0, l1);
        run_to(c + 21);
        bus_if.en = 1'b0;
        #1;
        check_eq("t5_gated", bus_if.os_tick, 0);
        step(1);
        bus_if.en = 1'b1;
        d = cyc;
        push_ticks(d, 20, 0, 0, 0, last);
        run_to(last + 1);
        bus_if.en = 1'b0;
        step(2);
        drain("t5_drain");

        // Async reset during a tick cycle
        wr(7, 0);
        bus_if.en = 1'b1;
        c = cyc;
        push_ticks(c, 1, 7, 0, 0, last);
        run_to(c + 14);
        #1;
        check_eq("t6_pre_rst_tick", bus_if.os_tick, 1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_os", bus_if.os_tick, 0);
        check_eq("t6_rst_bit", bus_if.bit_tick, 0);
        check_eq("t6_rst_pend", bus_if.upd_pend, 0);
        bus_if.en = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        drain("t6_pre_drain");
        bus_if.en = 1'b1;
        c = cyc;
        push_ticks(c, 2, 326, 0, 0, last);
        run_to(last + 1);
        bus_if.en = 1'b0;
        step(2);
        drain("t6_drain");

        // Write on the IDLE->RUN edge: start with old shadow, new one at first boundary
        wr(9, 0);
        bus_if.en       = 1'b1;
        bus_if.div_wr   = 1'b1;
        bus_if.div_data = 16'd3;
        c = cyc;
        push_ticks(c, 1, 9, 0, 0, l1);
        push_ticks(l1, 2, 3, 0, 1, last);
        step(1);
        bus_if.div_wr = 1'b0;
        check_eq("t7_pend", bus_if.upd_pend, 1);
        run_to(l1 + 1);
        check_eq("t7_applied", bus_if.upd_pend, 0);
        run_to(last + 1);
        bus_if.en = 1'b0;
        step(2);
        drain("t7_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
